// File: rtl/cb_cfg_loader.sv
// cb_cfg_loader: serializes parallel config words onto the connection-block shift chain.
// Optional readback CRC check of displaced chain contents: define CB_CFG_READBACK_EN.
module cb_cfg_loader #(
    parameter int CHAIN_LEN = 104,
    parameter int WORD_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              cfg_bit,
    output logic              prgm_b,
    output logic              cb_prgm_b,
    output logic              busy,
    output logic              done
`ifdef CB_CFG_READBACK_EN
    ,
    input  logic              rb_bit,
    output logic              rb_err
`endif
);
    localparam int N_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int BIT_CW  = $clog2(CHAIN_LEN + 1);
    localparam int REM_CW  = $clog2(WORD_W + 1);
    localparam int WRD_CW  = $clog2(N_WORDS + 1);
    localparam logic [BIT_CW-1:0] BITS_LAST  = BIT_CW'(CHAIN_LEN);
    localparam logic [WRD_CW-1:0] WORDS_LAST = WRD_CW'(N_WORDS);
    localparam logic [REM_CW-1:0] REM_FULL   = REM_CW'(WORD_W);
    localparam logic [REM_CW-1:0] REM_ONE    = REM_CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BIT_CW-1:0] r_bits_sent;
    logic [WRD_CW-1:0] r_words;
    logic [REM_CW-1:0] r_rem;
    logic [WORD_W-1:0] r_sh;
    logic              r_cfg_bit;
    logic              r_prgm_b;
    logic              r_cb_prgm_b;

    logic              w_in_shift;
    logic              w_room;
    logic              w_reg_emit;
    logic              w_ready;
    logic              w_accept;
    logic              w_emit;
    logic              w_bit;
    logic [WORD_W-1:0] w_src;
    logic [WORD_W-1:0] w_src_adv;

    // An empty holding register takes its first bit straight from s_data, so
    // acceptance and the first emitted bit share one edge and no bubble appears.
    always_comb begin
        w_in_shift = (r_state == S_SHIFT);
        w_room     = w_in_shift && (r_bits_sent < BITS_LAST);
        w_reg_emit = w_room && (r_rem != '0);
        w_ready    = w_in_shift && (r_words < WORDS_LAST) &&
                     ((r_rem == '0) || ((r_rem == REM_ONE) && w_reg_emit));
        w_accept   = w_ready && s_valid;
        w_emit     = w_reg_emit || (w_room && w_accept);
        w_src      = (r_rem == '0) ? s_data : r_sh;
        w_bit      = MSB_FIRST ? w_src[WORD_W-1] : w_src[0];
        w_src_adv  = MSB_FIRST ? (w_src << 1) : (w_src >> 1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_bits_sent == BITS_LAST) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bits_sent <= '0;
            r_words     <= '0;
            r_rem       <= '0;
            r_cfg_bit   <= 1'b0;
            r_prgm_b    <= 1'b1;
            r_cb_prgm_b <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prgm_b    <= !((w_state_nxt == S_SHIFT) || (w_state_nxt == S_DRAIN));
            r_cb_prgm_b <= w_emit;
            if ((r_state == S_IDLE) && start) begin
                r_bits_sent <= '0;
                r_words     <= '0;
                r_rem       <= '0;
            end else begin
                if (w_emit) begin
                    r_cfg_bit   <= w_bit;
                    r_bits_sent <= r_bits_sent + 1'b1;
                end
                if (w_accept) begin
                    r_words <= r_words + 1'b1;
                    r_rem   <= (r_rem == '0) ? (REM_FULL - 1'b1) : REM_FULL;
                end else if (w_emit) begin
                    r_rem <= r_rem - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_sh <= (r_rem == '0) ? w_src_adv : s_data;
        end else if (w_emit) begin
            r_sh <= w_src_adv;
        end
    end

    assign s_ready   = w_ready;
    assign cfg_bit   = r_cfg_bit;
    assign prgm_b    = r_prgm_b;
    assign cb_prgm_b = r_cb_prgm_b;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

`ifdef CB_CFG_READBACK_EN
    logic       r_rb_stb;
    logic [7:0] r_rb_crc;
    logic [7:0] r_tx_crc;
    logic [7:0] r_prev_crc;
    logic       r_rb_err;
    logic [7:0] w_rb_crc_nxt;
    logic [7:0] w_tx_crc_nxt;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    always_comb begin
        w_rb_crc_nxt = r_rb_stb ? crc8_step(r_rb_crc, rb_bit) : r_rb_crc;
        w_tx_crc_nxt = w_emit ? crc8_step(r_tx_crc, w_bit) : r_tx_crc;
    end

    // The final readback sample lands in DRAIN, so the compare uses the
    // updated CRC and the verdict is visible together with done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rb_stb   <= 1'b0;
            r_rb_crc   <= 8'h00;
            r_tx_crc   <= 8'h00;
            r_prev_crc <= 8'h00;
            r_rb_err   <= 1'b0;
        end else begin
            r_rb_stb <= r_cb_prgm_b;
            if (r_state == S_DRAIN) begin
                r_rb_err   <= (w_rb_crc_nxt != r_prev_crc);
                r_prev_crc <= r_tx_crc;
                r_rb_crc   <= 8'h00;
                r_tx_crc   <= 8'h00;
            end else begin
                if ((r_state == S_IDLE) && start) r_rb_err <= 1'b0;
                r_rb_crc <= w_rb_crc_nxt;
                r_tx_crc <= w_tx_crc_nxt;
            end
        end
    end

    assign rb_err = r_rb_err;
`endif
endmodule
